// File: rtl/ddr5_cmd_sched.sv
// Single-bank DDR5 command scheduler: turns RD/WR/WRP/MR requests into PRE/ACT/CAS/MR
// command codes for the packet-generator control stage, honouring the bank timing windows.
module ddr5_cmd_sched #(
  parameter int ROW_W = 16,
  parameter int COL_W = 10,
  parameter int CNT_W = 6,
  parameter int T_RCD = 4,
  parameter int T_RP  = 3,
  parameter int T_RAS = 8,
  parameter int T_WR  = 6,
  parameter int T_RTP = 3,
  parameter int T_MRD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_type,
  input  logic             req_ap,
  input  logic [ROW_W-1:0] req_row,
  input  logic [COL_W-1:0] req_col,
  input  logic [7:0]       req_mra,
  input  logic [7:0]       req_mrd,
  output logic [3:0]       current_state,
  output logic             cmd_phase,
  output logic [ROW_W-1:0] cmd_row,
  output logic [COL_W-1:0] cmd_col,
  output logic [7:0]       cmd_mra,
  output logic [7:0]       cmd_mrd,
  output logic             row_open,
  output logic             cmd_done
);

  localparam logic [3:0] C_IDLE = 4'd0;
  localparam logic [3:0] C_ACT  = 4'd8;
  localparam logic [3:0] C_WRP  = 4'd1;
  localparam logic [3:0] C_WRPA = 4'd3;
  localparam logic [3:0] C_MRW  = 4'd2;
  localparam logic [3:0] C_MRR  = 4'd6;
  localparam logic [3:0] C_WR   = 4'd7;
  localparam logic [3:0] C_WRA  = 4'd5;
  localparam logic [3:0] C_RD   = 4'd4;
  localparam logic [3:0] C_RDA  = 4'd12;
  localparam logic [3:0] C_PRE  = 4'd13;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_WRP_WAIT, S_ACT, S_RCD_WAIT, S_CAS, S_MR, S_MRD_WAIT
  } state_e;

  state_e             state_q, state_d;
  logic               req_ready_q, req_ready_d;
  logic [3:0]         cur_q, cur_d;
  logic               phase_q, phase_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [7:0]         mra_q, mra_d;
  logic [7:0]         mrd_q, mrd_d;
  logic               row_open_q, row_open_d;
  logic               done_q, done_d;
  logic [2:0]         typ_q, typ_d;
  logic               ap_q, ap_d;
  logic [ROW_W-1:0]   rrow_q, rrow_d;
  logic [COL_W-1:0]   rcol_q, rcol_d;
  logic [7:0]         rmra_q, rmra_d;
  logic [7:0]         rmrd_q, rmrd_d;
  logic [CNT_W-1:0]   since_act_q, since_act_d;
  logic [CNT_W-1:0]   since_pre_q, since_pre_d;
  logic [CNT_W-1:0]   since_w_q, since_w_d;
  logic [CNT_W-1:0]   since_r_q, since_r_d;
  logic [CNT_W-1:0]   since_mr_q, since_mr_d;

  logic       is_mr, is_write, pre_ok, act_ok, cas_ok;
  logic [3:0] cas_code, mr_code;

  // Each since_* counter reads 0 on the edge its command's first cycle is registered.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    sat_inc = (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // True when a command registered on the coming edge is at least t cycles after the counted one.
  function automatic logic met(input logic [CNT_W-1:0] c, input int t);
    met = (int'(c) + 1) >= t;
  endfunction

  always_comb begin
    is_mr    = (typ_q == 3'd3) || (typ_q == 3'd4);
    is_write = (typ_q != 3'd0);
    mr_code  = (typ_q == 3'd3) ? C_MRW : C_MRR;
    case (typ_q)
      3'd0:    cas_code = ap_q ? C_RDA : C_RD;
      3'd1:    cas_code = ap_q ? C_WRA : C_WR;
      default: cas_code = ap_q ? C_WRPA : C_WRP;
    endcase
    pre_ok = met(since_act_q, T_RAS) && met(since_w_q, T_WR) && met(since_r_q, T_RTP);
    // Write/read recovery plus tRP also covers the implicit precharge of auto-precharge CAS.
    act_ok = met(since_pre_q, T_RP) && met(since_w_q, T_WR + T_RP) &&
             met(since_r_q, T_RTP + T_RP);
    cas_ok = met(since_act_q, T_RCD);
  end

  // Handshake: a request transfers on the rising edge where req_valid && req_ready are both 1;
  // req_ready is registered, high only in S_IDLE, and drops for the whole life of a request.
  always_comb begin
    state_d     = state_q;
    cur_d       = C_IDLE;
    phase_d     = 1'b0;
    done_d      = 1'b0;
    row_d       = row_q;
    col_d       = col_q;
    mra_d       = mra_q;
    mrd_d       = mrd_q;
    typ_d       = typ_q;
    ap_d        = ap_q;
    rrow_d      = rrow_q;
    rcol_d      = rcol_q;
    rmra_d      = rmra_q;
    rmrd_d      = rmrd_q;
    since_act_d = sat_inc(since_act_q);
    since_pre_d = sat_inc(since_pre_q);
    since_w_d   = sat_inc(since_w_q);
    since_r_d   = sat_inc(since_r_q);
    since_mr_d  = sat_inc(since_mr_q);

    row_open_d = row_open_q;
    if (cur_q == C_ACT && phase_q) row_open_d = 1'b1;
    if (cur_q == C_PRE) row_open_d = 1'b0;
    if (phase_q && (cur_q == C_RDA || cur_q == C_WRA || cur_q == C_WRPA)) row_open_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          typ_d  = req_type;
          ap_d   = req_ap;
          rrow_d = req_row;
          rcol_d = req_col;
          rmra_d = req_mra;
          rmrd_d = req_mrd;
          if (req_type > 3'd4)       state_d = S_MRD_WAIT;
          else if (req_type >= 3'd3) state_d = row_open_q ? S_PRE : S_MR;
          else if (row_open_q)       state_d = (req_row == row_q) ? S_CAS : S_PRE;
          else                       state_d = S_ACT;
        end
      end
      S_PRE: begin
        if (pre_ok) begin
          cur_d       = C_PRE;
          since_pre_d = '0;
          if (T_RP <= 2) state_d = is_mr ? S_MR : S_ACT;
          else           state_d = S_WRP_WAIT;
        end
      end
      S_WRP_WAIT: begin
        if (met(since_pre_q, T_RP - 1)) state_d = is_mr ? S_MR : S_ACT;
      end
      S_ACT: begin
        if (cur_q == C_ACT && !phase_q) begin
          cur_d   = C_ACT;
          phase_d = 1'b1;
          state_d = (T_RCD <= 2) ? S_CAS : S_RCD_WAIT;
        end else if (act_ok) begin
          cur_d       = C_ACT;
          since_act_d = '0;
          row_d       = rrow_q;
        end
      end
      S_RCD_WAIT: begin
        if (met(since_act_q, T_RCD - 1)) state_d = S_CAS;
      end
      S_CAS: begin
        if (cur_q == cas_code && phase_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (cur_q == cas_code) begin
          cur_d   = cas_code;
          phase_d = 1'b1;
        end else if (cas_ok) begin
          cur_d = cas_code;
          col_d = rcol_q;
          if (is_write) since_w_d = '0;
          else          since_r_d = '0;
        end
      end
      S_MR: begin
        if (cur_q == mr_code && !phase_q) begin
          cur_d   = mr_code;
          phase_d = 1'b1;
          state_d = S_MRD_WAIT;
        end else if (act_ok) begin
          cur_d      = mr_code;
          since_mr_d = '0;
          mra_d      = rmra_q;
          mrd_d      = rmrd_q;
        end
      end
      S_MRD_WAIT: begin
        // Reserved request types also park here for one cycle before completing.
        if (typ_q > 3'd4 || met(since_mr_q, T_MRD)) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b0;
      cur_q       <= C_IDLE;
      phase_q     <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      mra_q       <= '0;
      mrd_q       <= '0;
      row_open_q  <= 1'b0;
      done_q      <= 1'b0;
      typ_q       <= '0;
      ap_q        <= 1'b0;
      rrow_q      <= '0;
      rcol_q      <= '0;
      rmra_q      <= '0;
      rmrd_q      <= '0;
      since_act_q <= '1;
      since_pre_q <= '1;
      since_w_q   <= '1;
      since_r_q   <= '1;
      since_mr_q  <= '1;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      cur_q       <= cur_d;
      phase_q     <= phase_d;
      row_q       <= row_d;
      col_q       <= col_d;
      mra_q       <= mra_d;
      mrd_q       <= mrd_d;
      row_open_q  <= row_open_d;
      done_q      <= done_d;
      typ_q       <= typ_d;
      ap_q        <= ap_d;
      rrow_q      <= rrow_d;
      rcol_q      <= rcol_d;
      rmra_q      <= rmra_d;
      rmrd_q      <= rmrd_d;
      since_act_q <= since_act_d;
      since_pre_q <= since_pre_d;
      since_w_q   <= since_w_d;
      since_r_q   <= since_r_d;
      since_mr_q  <= since_mr_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign current_state = cur_q;
  assign cmd_phase     = phase_q;
  assign cmd_row       = row_q;
  assign cmd_col       = col_q;
  assign cmd_mra       = mra_q;
  assign cmd_mrd       = mrd_q;
  assign row_open      = row_open_q;
  assign cmd_done      = done_q;

endmodule

// File: tb/tb_ddr5_cmd_sched.sv
// Bench for ddr5_cmd_sched: a timeline model schedules every command edge from the timing
// rules and a per-edge compare process checks the DUT against it.
module tb_ddr5_cmd_sched;

  localparam int ROW_W = 16;
  localparam int COL_W = 10;
  localparam int CNT_W = 6;
  localparam int T_RCD = 4;
  localparam int T_RP  = 3;
  localparam int T_RAS = 8;
  localparam int T_WR  = 6;
  localparam int T_RTP = 3;
  localparam int T_MRD = 4;
  localparam int NEVER = -1000;

  // clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [2:0]       req_type = '0;
  logic             req_ap = 1'b0;
  logic [ROW_W-1:0] req_row = '0;
  logic [COL_W-1:0] req_col = '0;
  logic [7:0]       req_mra = '0;
  logic [7:0]       req_mrd = '0;
  logic [3:0]       current_state;
  logic             cmd_phase;
  logic [ROW_W-1:0] cmd_row;
  logic [COL_W-1:0] cmd_col;
  logic [7:0]       cmd_mra;
  logic [7:0]       cmd_mrd;
  logic             row_open;
  logic             cmd_done;

  ddr5_cmd_sched #(
    .ROW_W(ROW_W), .COL_W(COL_W), .CNT_W(CNT_W), .T_RCD(T_RCD), .T_RP(T_RP),
    .T_RAS(T_RAS), .T_WR(T_WR), .T_RTP(T_RTP), .T_MRD(T_MRD)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_ap(req_ap), .req_row(req_row), .req_col(req_col),
    .req_mra(req_mra), .req_mrd(req_mrd), .current_state(current_state),
    .cmd_phase(cmd_phase), .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_mra(cmd_mra),
    .cmd_mrd(cmd_mrd), .row_open(row_open), .cmd_done(cmd_done)
  );

  // scoreboard: expected command stream {edge[15:0], code[3:0], phase}
  logic [20:0] exp_q[$];
  logic [16:0] ro_q[$];
  typedef struct {
    int               edge_n;
    int               kind;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [7:0]       mra;
    logic [7:0]       mrd;
  } done_t;
  done_t done_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_from = 1 << 30;
  logic mdl_ro = 1'b0;

  bit               m_open;
  logic [ROW_W-1:0] m_row;
  int               last_act, last_pre, last_w, last_r;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s edge %0d got %0h want %0h", name, cyc, got, want);
    end
  endtask

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [3:0] code_of(input logic [2:0] typ, input bit ap);
    case (typ)
      3'd0:    return ap ? 4'd12 : 4'd4;
      3'd1:    return ap ? 4'd5 : 4'd7;
      3'd2:    return ap ? 4'd3 : 4'd1;
      3'd3:    return 4'd2;
      default: return 4'd6;
    endcase
  endfunction

  task automatic push_cmd(input int e, input logic [3:0] code, input bit two);
    exp_q.push_back({e[15:0], code, 1'b0});
    if (two) exp_q.push_back({e[15:0] + 16'd1, code, 1'b1});
  endtask

  task automatic model_reset();
    exp_q.delete();
    ro_q.delete();
    done_q.delete();
    m_open   = 1'b0;
    m_row    = '0;
    last_act = NEVER;
    last_pre = NEVER;
    last_w   = NEVER;
    last_r   = NEVER;
    rdy_from = 1 << 30;
  endtask

  // driver: present one request when the model says the scheduler is idle, and schedule it
  task automatic send(input logic [2:0] typ, input bit ap, input logic [ROW_W-1:0] row,
                      input logic [COL_W-1:0] col, input logic [7:0] mra, input logic [7:0] mrd,
                      output int acc, output int t_pre, output int t_act, output int t_cmd,
                      output int t_done);
    int t;
    done_t d;
    while (cyc < rdy_from) @(negedge clk);
    req_type = typ; req_ap = ap; req_row = row; req_col = col; req_mra = mra; req_mrd = mrd;
    req_valid = 1'b1;
    acc = cyc + 1;
    t_pre = -1; t_act = -1; t_cmd = -1;
    t = acc + 1;
    d.row = '0; d.col = col; d.mra = mra; d.mrd = mrd;
    if (typ > 3'd4) begin
      t_done = acc + 1;
      d.kind = 2;
    end else begin
      if (m_open && !(typ <= 3'd2 && row == m_row)) begin
        t_pre = max2(max2(t, last_act + T_RAS), max2(last_w + T_WR, last_r + T_RTP));
        push_cmd(t_pre, 4'd13, 1'b0);
        ro_q.push_back({t_pre[15:0] + 16'd1, 1'b0});
        last_pre = t_pre;
        m_open = 1'b0;
        t = t_pre + 1;
      end
      if (typ <= 3'd2) begin
        if (!m_open) begin
          t_act = max2(max2(t, last_pre + T_RP), max2(last_w + T_WR + T_RP, last_r + T_RTP + T_RP));
          push_cmd(t_act, 4'd8, 1'b1);
          ro_q.push_back({t_act[15:0] + 16'd2, 1'b1});
          last_act = t_act;
          m_row = row;
          m_open = 1'b1;
          t = t_act + 2;
        end
        t_cmd = max2(t, last_act + T_RCD);
        push_cmd(t_cmd, code_of(typ, ap), 1'b1);
        if (typ == 3'd0) last_r = t_cmd;
        else             last_w = t_cmd;
        if (ap) begin
          m_open = 1'b0;
          ro_q.push_back({t_cmd[15:0] + 16'd2, 1'b0});
        end
        t_done = t_cmd + 2;
        d.kind = 0;
      end else begin
        t_cmd = max2(max2(t, last_pre + T_RP), max2(last_w + T_WR + T_RP, last_r + T_RTP + T_RP));
        push_cmd(t_cmd, code_of(typ, 1'b0), 1'b1);
        t_done = max2(t_cmd + T_MRD, t_cmd + 2);
        d.kind = 1;
      end
    end
    d.row = m_row;
    d.edge_n = t_done;
    done_q.push_back(d);
    rdy_from = t_done;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // compare process: checks every edge's registered outputs 1 time unit after the edge
  logic        rst_s;
  logic [20:0] ent;
  logic [16:0] rent;
  logic [3:0]  exp_c;
  logic        exp_p;
  logic        exp_d;
  done_t       dent;

  always begin
    @(posedge clk);
    cyc = cyc + 1;
    rst_s = rst;
    #1;
    if (rst_s) begin
      mdl_ro = 1'b0;
      chk("reset_outputs", {req_ready, current_state, cmd_phase, row_open, cmd_done,
                            cmd_row, cmd_col, cmd_mra, cmd_mrd}, '0);
    end else begin
      exp_c = 4'd0;
      exp_p = 1'b0;
      if (exp_q.size() > 0) begin
        ent = exp_q[0];
        if (ent[20:5] == cyc[15:0]) begin
          exp_c = ent[4:1];
          exp_p = ent[0];
          ent = exp_q.pop_front();
        end
      end
      chk("cmd_code_phase", {current_state, cmd_phase}, {exp_c, exp_p});
      exp_d = 1'b0;
      if (done_q.size() > 0 && done_q[0].edge_n == cyc) begin
        exp_d = 1'b1;
        dent = done_q.pop_front();
        if (dent.kind == 0) chk("cas_fields", {cmd_row, cmd_col}, {dent.row, dent.col});
        if (dent.kind == 1) chk("mr_fields", {cmd_row, cmd_mra, cmd_mrd}, {dent.row, dent.mra, dent.mrd});
      end
      chk("cmd_done", cmd_done, exp_d);
      while (ro_q.size() > 0) begin
        rent = ro_q[0];
        if (rent[16:1] != cyc[15:0]) break;
        mdl_ro = rent[0];
        rent = ro_q.pop_front();
      end
      chk("row_open", row_open, mdl_ro);
      chk("req_ready", req_ready, cyc >= rdy_from);
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog edge %0d got timeout want finish", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  int acc, t_pre, t_act, t_cmd, t_done, w_cas, rda_cas;

  initial begin
    model_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rdy_from = cyc + 1;

    // row closed: ACT, tRCD gap, RD
    send(3'd0, 1'b0, 16'h12, 10'h8, 8'h0, 8'h0, acc, t_pre, t_act, t_cmd, t_done);
    chk("pin_act_after_accept", t_act, acc + 1);
    chk("pin_rd_after_trcd", t_cmd, acc + 5);
    chk("pin_rd_done", t_done, acc + 7);

    // row hit: no ACT
    send(3'd1, 1'b0, 16'h12, 10'h20, 8'h0, 8'h0, acc, t_pre, t_act, t_cmd, t_done);
    chk("pin_hit_no_act", t_act, -1);
    chk("pin_hit_cas", t_cmd, acc + 1);
    chk("pin_hit_done", t_done, acc + 3);
    w_cas = t_cmd;

    // row miss after a write: PRE held off by write recovery
    send(3'd0, 1'b0, 16'h34, 10'h40, 8'h0, 8'h0, acc, t_pre, t_act, t_cmd, t_done);
    chk("pin_pre_twr", t_pre, w_cas + 6);
    chk("pin_act_trp", t_act, t_pre + 3);
    chk("pin_cas_trcd", t_cmd, t_act + 4);

    // auto-precharge read hit, then reopen the same row
    send(3'd0, 1'b1, 16'h34, 10'h41, 8'h0, 8'h0, acc, t_pre, t_act, t_cmd, t_done);
    chk("pin_rda_hit", t_cmd, acc + 1);
    rda_cas = t_cmd;
    send(3'd0, 1'b0, 16'h34, 10'h42, 8'h0, 8'h0, acc, t_pre, t_act, t_cmd, t_done);
    chk("pin_act_after_rda", t_act, rda_cas + 6);

    // mode-register write with a row open
    send(3'd3, 1'b0, 16'h0, 10'h0, 8'h0A, 8'h5C, acc, t_pre, t_act, t_cmd, t_done);
    chk("pin_mrw_trp", t_cmd, t_pre + 3);
    chk("pin_mrw_done", t_done, t_cmd + 4);

    // mode-register read with row closed, then a reserved type
    send(3'd4, 1'b0, 16'h0, 10'h0, 8'h03, 8'h00, acc, t_pre, t_act, t_cmd, t_done);
    chk("pin_mrr_direct", t_cmd, acc + 1);
    send(3'd6, 1'b0, 16'h0, 10'h0, 8'h00, 8'h00, acc, t_pre, t_act, t_cmd, t_done);
    chk("pin_reserved_done", t_done, acc + 1);

    // write-pattern with AP, then a write to the same (now closed) row
    send(3'd2, 1'b1, 16'h55, 10'h3, 8'h0, 8'h0, acc, t_pre, t_act, t_cmd, t_done);
    w_cas = t_cmd;
    send(3'd1, 1'b1, 16'h55, 10'h4, 8'h0, 8'h0, acc, t_pre, t_act, t_cmd, t_done);
    chk("pin_act_after_wrpa", t_act, w_cas + 9);

    // reset while waiting out tRCD
    send(3'd0, 1'b0, 16'h66, 10'h5, 8'h0, 8'h0, acc, t_pre, t_act, t_cmd, t_done);
    while (cyc < t_act + 2) @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    rdy_from = cyc + 1;

    send(3'd0, 1'b0, 16'h66, 10'h1, 8'h0, 8'h0, acc, t_pre, t_act, t_cmd, t_done);
    chk("pin_act_after_reset", t_act, acc + 1);
    while (cyc < t_done + 2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr5_cmd_sched.md
Name: ddr5_cmd_sched

Overview:
- Single-bank DDR5 command scheduler. Sits directly upstream of the packet-generator control stage and drives its 4-bit current_state command code.
- Accepts read, write, write-pattern and mode-register requests over a valid/ready handshake.
- Tracks the open row and issues the required PRE/ACT/CAS/MR command sequence, honouring tRCD, tRP, tRAS, write recovery, tRTP and tMRD.
- Holds each command code for its native 1 or 2 cycles.

Parameters:
- ROW_W, 16, row address width
- COL_W, 10, column address width
- CNT_W, 6, width of every timing counter
- T_RCD, 4, cycles from ACT first cycle to CAS first cycle (>=2)
- T_RP, 3, cycles from PRE to ACT/MR first cycle (>=1)
- T_RAS, 8, minimum cycles from ACT first cycle to PRE
- T_WR, 6, cycles from write-type CAS first cycle to PRE
- T_RTP, 3, cycles from read CAS first cycle to PRE
- T_MRD, 4, cycles from MR command first cycle to done

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  scheduler can accept
- req_type  in  3  0=RD, 1=WR, 2=WRP, 3=MRW, 4=MRR; 5-7 reserved
- req_ap  in  1  auto-precharge (RD/WR/WRP only)
- req_row  in  ROW_W  row address
- req_col  in  COL_W  column address
- req_mra  in  8  mode-register address
- req_mrd  in  8  mode-register write data
- current_state  out  4  command code: IDLE=0, ACT=8, WRP=1, WRPA=3, MRW=2, MRR=6, WR=7, WRA=5, RD=4, RDA=12, PRE=13
- cmd_phase  out  1  0 = first command cycle, 1 = second
- cmd_row  out  ROW_W  row for ACT
- cmd_col  out  COL_W  column for CAS
- cmd_mra  out  8  MR address
- cmd_mrd  out  8  MR data
- row_open  out  1  a row is open
- cmd_done  out  1  one-cycle pulse at request completion

Behaviour:
- All outputs are registered. Reset state: current_state=0, cmd_phase=0, req_ready=0, row_open=0, cmd_done=0, and all address outputs 0.
- Reset clears all timing counters to "satisfied" and discards any in-flight request.
- req_ready=1 only in S_IDLE. In the first cycle after rst deasserts, req_ready=1.
- A request is accepted on the edge where req_valid && req_ready. All request fields are latched. req_ready drops on the following cycle and stays low until cmd_done.
- Reserved req_type values are accepted and then dropped: cmd_done pulses the next cycle and no command is issued.
- States: S_IDLE, S_PRE, S_WRP_WAIT, S_ACT, S_RCD_WAIT, S_CAS, S_MR, S_MRD_WAIT.
- Decision at accept (CAS-type request):
  - row open and row hit: go to S_CAS.
  - row open and row miss: go to S_PRE.
  - row closed: go to S_ACT.
- Decision at accept (MR-type request):
  - row open: go to S_PRE.
  - row closed: go to S_MR.
- Each command is issued on the first cycle at which all of its constraints are met; current_state=0 on every non-command cycle.
- Command lengths: PRE is 1 cycle (phase 0). ACT, RD, RDA, WR, WRA, WRP, WRPA, MRW and MRR are 2 cycles (phase 0 then phase 1), with the same code on both cycles.
- Constraints, measured between command first cycles:
  - PRE >= ACT + T_RAS
  - PRE >= write CAS + T_WR
  - PRE >= read CAS + T_RTP
  - ACT or MR >= PRE + T_RP
  - CAS >= ACT + T_RCD
  - Constraints not tied to a prior command (e.g. after reset) are already satisfied.
- Auto-precharge: when req_ap=1, the CAS code is RDA, WRA or WRPA and row_open clears after that command's phase 1. The next ACT or MR is gated by read CAS + T_RTP + T_RP, or by write CAS + T_WR + T_RP.
- row_open sets after ACT phase 1 and clears after PRE. The open row register loads at ACT.
- cmd_done fires in the cycle after CAS phase 1. For MR requests it fires when S_MRD_WAIT reaches MR first cycle + T_MRD. The scheduler returns to S_IDLE in the same cycle.
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-sequence: abandon the sequence at the next edge with no partial command completion; the 2-cycle code is truncated.

Test Plan:
- Reset, row closed, accept RD row=0x12 col=0x8, ap=0 at edge e0: current_state is 8,8 at e0+1..e0+2; 0,0; 4,4 at e0+5..e0+6. cmd_done at e0+7, row_open=1, cmd_row=0x12, cmd_col=0x8.
- Follow with WR row=0x12 (hit): 7,7 issued in the cycle after accept with no ACT. cmd_done two cycles later.
- Then RD row=0x34 (miss) issued immediately: PRE(13) waits for T_WR=6 after the WR first cycle. ACT follows at PRE+3, and RD (4,4) at ACT+4.
- RD ap=1 row=0x34 (hit): RDA code 12,12, then row_open=0. Next RD row=0x34 issues ACT no earlier than RDA+6 (T_RTP+T_RP).
- MRW mra=0x0A mrd=0x5C with row open: PRE, then MRW (2,2) at PRE+3 with cmd_mra=0x0A and cmd_mrd=0x5C. cmd_done at MRW+4; req_ready stays low throughout.
- Assert rst during S_RCD_WAIT: the next cycle shows all outputs at reset values and row_open=0. A new RD then starts with ACT immediately after accept.
